// File: rtl/eth_clk_gen_multi.sv
// Multi-channel divided clock generator with glitch-free divide updates and park-on-disable.
// Define ETH_CLK_GEN_PHASE90_EN to build the 90-degree-shifted clk90_o outputs (tied to 0 otherwise).
module eth_clk_gen_multi #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 4,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic [NUM_CH-1:0]       div_valid_i,
    output logic [NUM_CH-1:0]       div_ready_o,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       clk90_o,
    output logic [NUM_CH*DIV_W-1:0] cycl_count_o
);

    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
    localparam logic [DIV_W-1:0] RST_DIV = (DEFAULT_DIV < 2) ? MIN_DIV : DIV_W'(DEFAULT_DIV);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] pend_val_q;
        logic             pend_q;
        logic             ready_q;
        logic             clk_q;
        logic [DIV_W-1:0] div_in;
        logic [DIV_W-1:0] div_sat;
        logic [DIV_W-1:0] div_nxt;
        logic [DIV_W-1:0] cnt_nxt;
        logic [DIV_W:0]   half_nxt;
        logic             accept;
        logic             wrap;
        logic             load;

        // Pending values only load at the D-1 point, which covers both a running wrap and a parked channel.
        always_comb begin
            div_in   = div_i[c*DIV_W +: DIV_W];
            div_sat  = (div_in < MIN_DIV) ? MIN_DIV : div_in;
            accept   = div_valid_i[c] & ready_q;
            wrap     = (cnt_q == div_q - 1'b1);
            load     = wrap & pend_q;
            div_nxt  = load ? pend_val_q : div_q;
            if (wrap) begin
                cnt_nxt = en_i[c] ? '0 : div_nxt - 1'b1;
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
            half_nxt = ({1'b0, div_nxt} + 1'b1) >> 1;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                div_q      <= RST_DIV;
                cnt_q      <= RST_DIV - 1'b1;
                pend_val_q <= RST_DIV;
                pend_q     <= 1'b0;
                ready_q    <= 1'b1;
                clk_q      <= 1'b0;
            end else begin
                div_q   <= div_nxt;
                cnt_q   <= cnt_nxt;
                ready_q <= ~accept & ~pend_q;
                clk_q   <= ({1'b0, cnt_nxt} < half_nxt);
                if (accept) begin
                    pend_q     <= 1'b1;
                    pend_val_q <= div_sat;
                end else if (load) begin
                    pend_q <= 1'b0;
                end
            end
        end

`ifdef ETH_CLK_GEN_PHASE90_EN
        logic [DIV_W:0] quarter_nxt;
        logic [DIV_W:0] phase_nxt;
        logic           clk90_q;

        always_comb begin
            quarter_nxt = {1'b0, div_nxt} >> 2;
            if ({1'b0, cnt_nxt} >= quarter_nxt) begin
                phase_nxt = {1'b0, cnt_nxt} - quarter_nxt;
            end else begin
                phase_nxt = {1'b0, cnt_nxt} + {1'b0, div_nxt} - quarter_nxt;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                clk90_q <= 1'b0;
            end else begin
                clk90_q <= (phase_nxt < half_nxt);
            end
        end

        assign clk90_o[c] = clk90_q;
`else
        assign clk90_o[c] = 1'b0;
`endif

        assign div_ready_o[c]                 = ready_q;
        assign clk_o[c]                       = clk_q;
        assign cycl_count_o[c*DIV_W +: DIV_W] = cnt_q;
    end

endmodule

// File: tb/tb_eth_clk_gen_multi.sv
// Directed scoreboard bench for eth_clk_gen_multi (NUM_CH=2, DIV_W=4, DEFAULT_DIV=4).
module tb_eth_clk_gen_multi;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*DIV_W-1:0] div;
    logic [NUM_CH-1:0]       dv;
    logic [NUM_CH-1:0]       rdy;
    logic [NUM_CH-1:0]       co;
    logic [NUM_CH-1:0]       c90;
    logic [NUM_CH*DIV_W-1:0] cc;

    always #5 clk = ~clk;

    eth_clk_gen_multi #(
        .NUM_CH     (NUM_CH),
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .div_i       (div),
        .div_valid_i (dv),
        .div_ready_o (rdy),
        .clk_o       (co),
        .clk90_o     (c90),
        .cycl_count_o(cc)
    );

    typedef struct {
        int   ch;
        int   cnt;
        int   d;
        logic r;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   e1       = 0;

    task automatic chk(input string tag, input int ch, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s ch%0d observed=%0d expected=%0d", tag, ch, obs, expv);
        end
    endtask

    task automatic tick();
        exp_t e;
        logic exp_clk;
        logic exp_c90;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e       = sb.pop_front();
            exp_clk = (e.cnt < (e.d + 1) / 2);
`ifdef ETH_CLK_GEN_PHASE90_EN
            exp_c90 = (((e.cnt - e.d / 4 + e.d) % e.d) < (e.d + 1) / 2);
`else
            exp_c90 = 1'b0;
`endif
            chk("cnt",   e.ch, cc[e.ch*DIV_W +: DIV_W], 4'(e.cnt));
            chk("clk",   e.ch, {3'b0, co[e.ch]},        {3'b0, exp_clk});
            chk("clk90", e.ch, {3'b0, c90[e.ch]},       {3'b0, exp_c90});
            chk("ready", e.ch, {3'b0, rdy[e.ch]},       {3'b0, e.r});
        end
    endtask

    task automatic t2(input int c0, input int d0, input logic r0, input int c1, input int d1, input logic r1);
        sb.push_back('{0, c0, d0, r0});
        sb.push_back('{1, c1, d1, r1});
        tick();
    endtask

    // Channel 1 free-runs at the default divide through the middle section.
    task automatic t(input int c0, input int d0, input logic r0);
        e1 = (e1 + 1) % 4;
        t2(c0, d0, r0, e1, 4, 1'b1);
    endtask

    initial begin
        rst = 1'b1; en = '0; dv = '0; div = '0;
        t2(3, 4, 1, 3, 4, 1);

        rst = 1'b0; en = 2'b11; e1 = 3;
        t(0, 4, 1); t(1, 4, 1); t(2, 4, 1); t(3, 4, 1); t(0, 4, 1); t(1, 4, 1);

        div[3:0] = 4'd6; dv = 2'b01;
        t(2, 4, 0); dv = '0;
        t(3, 4, 0); t(0, 6, 0); t(1, 6, 1); t(2, 6, 1); t(3, 6, 1); t(4, 6, 1); t(5, 6, 1); t(0, 6, 1);

        div[3:0] = 4'd1; dv = 2'b01;
        t(1, 6, 0); dv = '0;
        t(2, 6, 0); t(3, 6, 0); t(4, 6, 0); t(5, 6, 0); t(0, 2, 0); t(1, 2, 1); t(0, 2, 1); t(1, 2, 1);

        div[3:0] = 4'd5; dv = 2'b01;
        t(0, 2, 0); dv = '0;
        t(1, 2, 0); t(0, 5, 0); t(1, 5, 1); t(2, 5, 1); t(3, 5, 1); t(4, 5, 1); t(0, 5, 1); t(1, 5, 1);

        en = 2'b10;
        t(2, 5, 1); t(3, 5, 1); t(4, 5, 1); t(4, 5, 1); t(4, 5, 1);
        en = 2'b11;
        t(0, 5, 1); t(1, 5, 1);
        en = 2'b10;
        t(2, 5, 1);
        en = 2'b11;
        t(3, 5, 1); t(4, 5, 1); t(0, 5, 1);

        en = 2'b10;
        t(1, 5, 1); t(2, 5, 1); t(3, 5, 1); t(4, 5, 1); t(4, 5, 1);
        div[3:0] = 4'd0; dv = 2'b01;
        t(4, 5, 0); dv = '0;
        t(1, 2, 0); t(1, 2, 1);
        en = 2'b11;
        t(0, 2, 1); t(1, 2, 1);

        div = {4'd3, 4'd6}; dv = 2'b11;
        t2(0, 2, 0, 2, 4, 0); dv = '0;
        t2(1, 2, 0, 3, 4, 0);
        t2(0, 6, 0, 0, 3, 0);
        t2(1, 6, 1, 1, 3, 1);

        div[3:0] = 4'd9; dv = 2'b01;
        t2(2, 6, 0, 2, 3, 1); dv = '0; rst = 1'b1;
        t2(3, 4, 1, 3, 4, 1); rst = 1'b0;
        t2(0, 4, 1, 0, 4, 1);
        t2(1, 4, 1, 1, 4, 1);
        t2(2, 4, 1, 2, 4, 1);
        t2(3, 4, 1, 3, 4, 1);
        t2(0, 4, 1, 0, 4, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_clk_gen_multi.md
ETH_CLK_GEN_MULTI -- requirements
Module: eth_clk_gen_multi

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, number of independent divided-clock channels (1..8).
REQ-002 The block SHALL have parameter DIV_W, default 4, width of each channel's divide value.
REQ-003 The block SHALL have parameter DEFAULT_DIV, default 4, reset divide value of every channel.
REQ-004 The block SHALL have port clk_i, input, 1 bit, single reference clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit; reset is synchronous and active-high.
REQ-006 The block SHALL have port en_i, input, NUM_CH bits, per-channel run enable.
REQ-007 The block SHALL have port div_i, input, NUM_CH*DIV_W bits, new divide value; channel c uses slice [c*DIV_W +: DIV_W].
REQ-008 The block SHALL have port div_valid_i, input, NUM_CH bits, per-channel divide-update request.
REQ-009 The block SHALL have port div_ready_o, output, NUM_CH bits, per-channel update acceptance.
REQ-010 The block SHALL have port clk_o, output, NUM_CH bits, divided clocks.
REQ-011 The block SHALL have port clk90_o, output, NUM_CH bits, 90-degree-shifted divided clocks.
REQ-012 The block SHALL have port cycl_count_o, output, NUM_CH*DIV_W bits, per-channel phase counter.

Function
REQ-013 Each channel SHALL hold divide register D (DIV_W bits) and phase counter cnt; any value loaded into D that is below 2 SHALL be saturated to 2.
REQ-014 While running, cnt SHALL count 0..D-1 and wrap to 0, advancing by 1 per clk_i cycle.
REQ-015 With H = ceil(D/2), clk_o SHALL be 1 in exactly the cycles where cnt < H; the value SHALL come directly from a flop, with no combinational path from any input.
REQ-016 With Q = floor(D/4), clk90_o SHALL be 1 in exactly the cycles where ((cnt - Q) mod D) < H; it SHALL be registered like clk_o.
REQ-017 cycl_count_o SHALL equal cnt in every cycle.
REQ-018 Handshake: an update SHALL be accepted in a cycle where div_valid_i and div_ready_o are both 1. The value SHALL be latched as pending and div_ready_o SHALL drop the next cycle.
REQ-019 A pending value SHALL load into D on the cycle cnt wraps from D-1 to 0, so the new period starts at cnt=0 and no shortened high or low phase occurs.
REQ-020 div_ready_o SHALL return to 1 in the cycle after the pending value loads.
REQ-021 If the channel is parked when an update is accepted, the pending value SHALL load on the next cycle.
REQ-022 When en_i[c] falls, the channel SHALL finish the current period, then park with cnt held at D-1 and clk_o and clk90_o both 0.
REQ-023 A parked channel SHALL move to cnt=0 in the cycle after en_i[c] is sampled as 1.
REQ-024 Toggling en_i[c] low and high again within one period SHALL cause no park and no glitch.
REQ-025 Channels SHALL be fully independent; simultaneous updates on several channels SHALL each be accepted.

Reset
REQ-026 rst_i sampled high SHALL set, per channel: D=DEFAULT_DIV (saturated to at least 2), cnt=D-1 (parked), pending cleared, div_ready_o=1, clk_o=0, clk90_o=0.
REQ-027 Reset SHALL take priority over every other input and abort any pending update and any period in progress.
REQ-028 In the first cycle after rst_i falls with en_i[c]=1, cnt SHALL be 0 and clk_o SHALL be 1.

Configuration
REQ-029 The macro ETH_CLK_GEN_PHASE90_EN, when defined, SHALL compile in the clk90_o generation logic as specified in REQ-016.
REQ-030 When ETH_CLK_GEN_PHASE90_EN is undefined, clk90_o SHALL be tied to 0, no phase-90 logic SHALL be instantiated, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Reset, NUM_CH=2, en_i=11 -> both clk_o show period 4, pattern 1100; cycl_count_o shows 0,1,2,3.
REQ-032 With PHASE90_EN defined, D=4 -> clk90_o pattern 0110, aligned so cnt=1,2 are high; with D=8 -> high for cnt=2..5.
REQ-033 Ch0 running D=4; at cnt=1 request div_i=6 -> ready drops; period stays 4 until wrap; then 111000 pattern starts at cnt=0; ready high one cycle later.
REQ-034 div_i=0 or 1 requested -> D saturates to 2 and clk_o toggles every cycle; D=5 -> pattern 11100.
REQ-035 en_i[0] drops at cnt=1 with D=4 -> cnt continues 2,3 and holds 3, clk_o=0; ch1 unaffected. Re-enable -> cnt=0 and clk_o=1 the next cycle.
REQ-036 rst_i asserted while an update is pending at cnt=2 -> next cycle D=DEFAULT_DIV, pending lost, div_ready_o=1, outputs 0.
